spi_slv: RTL and testbench
==========================

// Module: spi_slv
// PURPOSE
//  SPI responder (slave) for the team's 16-bit SPI master; sits on the peripheral side of the link.
//  Mode 3: SCLK idles high, data driven on SCLK fall, sampled on SCLK rise, MSB first.
//  Oversamples SCLK/SS_n/MOSI with clk (SCLK period >= 8 clk; master uses 64).
//  Delivers each received word with a 1-clk rdy pulse and returns a preloaded response word on MISO.
// PARAMETERS
//  WIDTH  16  bits per frame; counters sized $clog2(WIDTH+1)
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      reset, asynchronous, active-low
//  SS_n     in   1      slave select from master, async to clk, active-low
//  SCLK     in   1      serial clock from master, async to clk, idle high
//  MOSI     in   1      serial data from master, async to clk
//  MISO     out  1      serial data to master = shft[WIDTH-1]
//  tx_data  in   WIDTH  response word for the next frame
//  wrt_tx   in   1      load tx_data into shift reg (honoured only in IDLE)
//  rx_data  out  WIDTH  last complete received word (held until next frame completes)
//  rdy      out  1      1-clk pulse: rx_data updated this cycle
//  frm_err  out  1      1-clk pulse: SS_n deasserted before WIDTH bits received
//  busy     out  1      high in ACTIVE and WAIT_SS
// BEHAVIOUR
//  Reset: shft=0, rx_data=0, bit_cnt=0, rdy=0, frm_err=0, busy=0, MISO=0, state=IDLE.
//  Sync: SCLK, SS_n, MOSI each pass 3 flops (reset values 1,1,0). rise = s2&~s3, fall = ~s2&s3
//   on SCLK; use stage-2 MOSI (aligned with SCLK s2) as sampled bit; ss_act = ~SS_n s2.
//  Shift reg shft[WIDTH-1:0]; mosi_bit flop; bit_cnt counts SCLK rises in a frame.
//  FSM:
//   IDLE: wrt_tx -> shft<=tx_data. ss_act -> ACTIVE, bit_cnt<=0. SCLK edges ignored.
//   ACTIVE: rise -> mosi_bit<=MOSI s2, bit_cnt++.
//     fall with bit_cnt!=0 -> shft<={shft[WIDTH-2:0],mosi_bit}; first fall (bit_cnt==0) no shift.
//     rise making bit_cnt==WIDTH -> rx_data<={shft[WIDTH-2:0],MOSI s2}, rdy=1 same edge, -> WAIT_SS.
//     ~ss_act before completion -> frm_err=1 for 1 clk, rx_data unchanged, -> IDLE.
//   WAIT_SS: all SCLK edges ignored; ~ss_act -> IDLE (no error).
//  MISO: always shft[WIDTH-1]; shows tx_data[WIDTH-1] before first rise, tx bit WIDTH-1-k after fall k.
//   Changes 3 clk after raw SCLK fall (>= half SCLK period before master samples).
//  wrt_tx in ACTIVE/WAIT_SS is ignored (no queueing). wrt_tx and ss_act same cycle in IDLE: load wins, then ACTIVE.
//  Latency: rdy asserted 3 clk after raw SCLK rise WIDTH.
//  Unloaded frame: shft holds leftover RX bits; MISO returns them (defined, not an error).
//  rst_n low mid-frame: immediate return to reset values; frame lost, no rdy/frm_err.
// TESTING
//  1 load tx_data=16'hA5C3, master sends 16'h1234 -> rdy once, rx_data=16'h1234, master rd_data=16'hA5C3.
//  2 back-to-back frames 16'hFFFF then 16'h0000, tx reloaded 16'h0F0F/16'hF0F0 in IDLE between
//    -> two rdy pulses, rx_data sequence FFFF,0000; master reads 0F0F,F0F0.
//  3 SS_n raised after 7 rises -> frm_err 1 clk, no rdy, rx_data keeps previous value, state IDLE.
//  4 wrt_tx=1 with tx_data=16'hDEAD during ACTIVE -> ignored; MISO stream unchanged from preloaded word.
//  5 extra 3 SCLK pulses after 16th rise while SS_n low -> no further rdy, rx_data unchanged.
//  6 rst_n pulsed low at bit 9 -> all outputs 0 next cycle; following full frame 16'h8001 -> rx_data=16'h8001.

Source files
------------

// File: rtl/spi_slv_if.sv
// spi_slv_if: the four-wire SPI link between the team's master and the responder
interface spi_slv_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_slv.sv
// spi_slv: mode-3 SPI responder, oversampled by clk, returns a preloaded word on MISO
module spi_slv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slv_if.slave         bus,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_wrt_tx,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rdy,
    output logic             o_frm_err,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_SS} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_sclk_sync;
    logic [1:0]       r_ss_sync;
    logic [1:0]       r_mosi_sync;
    logic [WIDTH-1:0] r_shft;
    logic [WIDTH-1:0] r_rx_data;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_mosi_bit;
    logic             r_rdy;
    logic             r_frm_err;
    logic             w_rise;
    logic             w_fall;
    logic             w_mosi;
    logic             w_ss_act;
    logic             w_last;
    logic             w_load;
    logic             w_clr;
    logic             w_sample;
    logic             w_shift;
    logic             w_done;
    logic             w_err;

    // SS_n and MOSI only feed logic from stage 2, so their third stage would have no load
    assign w_rise   = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_mosi   = r_mosi_sync[1];
    assign w_ss_act = ~r_ss_sync[1];
    assign w_last   = (r_bit_cnt == CW'(WIDTH - 1));

    // Bring the asynchronous link signals into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 3'b111;
            r_ss_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], bus.SCLK};
            r_ss_sync   <= {r_ss_sync[0], bus.SS_n};
            r_mosi_sync <= {r_mosi_sync[0], bus.MOSI};
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Frame sequencing: select opens a frame, the last rise or a lost select closes it
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_ss_act ? ACTIVE : IDLE;
            ACTIVE:  w_next = !w_ss_act ? IDLE : (w_rise && w_last) ? WAIT_SS : ACTIVE;
            WAIT_SS: w_next = w_ss_act ? WAIT_SS : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state and synchronised link events
    always_comb begin
        w_load   = (r_state == IDLE) && i_wrt_tx;
        w_clr    = (r_state == IDLE) && w_ss_act;
        w_sample = (r_state == ACTIVE) && w_ss_act && w_rise;
        w_shift  = (r_state == ACTIVE) && w_ss_act && w_fall && (r_bit_cnt != '0);
        w_done   = w_sample && w_last;
        w_err    = (r_state == ACTIVE) && !w_ss_act;
    end

    // Shift register: preload in IDLE, otherwise shift on falls after the first rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_shft <= '0;
        else if (w_load)
            r_shft <= i_tx_data;
        else if (w_shift)
            r_shft <= {r_shft[WIDTH-2:0], r_mosi_bit};
    end

    // Rise counter and the bit captured on each rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_mosi_bit <= 1'b0;
        end else begin
            if (w_clr)
                r_bit_cnt <= '0;
            else if (w_sample)
                r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_sample)
                r_mosi_bit <= w_mosi;
        end
    end

    // Completed word capture with its strobe, plus the aborted-frame strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data <= '0;
            r_rdy     <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_done)
                r_rx_data <= {r_shft[WIDTH-2:0], w_mosi};
            r_rdy     <= w_done;
            r_frm_err <= w_err;
        end
    end

    assign bus.MISO  = r_shft[WIDTH-1];
    assign o_rx_data = r_rx_data;
    assign o_rdy     = r_rdy;
    assign o_frm_err = r_frm_err;
    assign o_busy    = (r_state != IDLE);
endmodule

// File: tb/tb_spi_slv.sv
// tb_spi_slv: directed SPI frames against a cycle-scheduled expectation model of spi_slv
module tb_spi_slv;
    localparam int W = 16;
    localparam int H = 8;
    localparam int N = 8192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         wrt_tx = 1'b0;
    logic [W-1:0] rx_data;
    logic         rdy;
    logic         frm_err;
    logic         busy;
    logic [W-1:0] mi;

    spi_slv_if bus ();

    spi_slv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .i_tx_data (tx_data),
        .i_wrt_tx  (wrt_tx),
        .o_rx_data (rx_data),
        .o_rdy     (rdy),
        .o_frm_err (frm_err),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected events, indexed by the cycle in which they must be visible
    bit           exp_rdy [N];
    bit           exp_err [N];
    bit           exp_on  [N];
    bit           exp_off [N];
    bit           exp_rst [N];
    logic [W-1:0] exp_word[N];
    logic [W-1:0] m_rx = '0;
    bit           m_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Every cycle: advance the model by the events due now, then compare
    always @(negedge clk) begin
        if (cyc < N) begin
            if (exp_rst[cyc]) begin
                m_rx   = '0;
                m_busy = 1'b0;
            end
            if (exp_on[cyc])  m_busy = 1'b1;
            if (exp_off[cyc]) m_busy = 1'b0;
            if (exp_rdy[cyc]) m_rx = exp_word[cyc];
            chk("rdy", rdy, exp_rdy[cyc]);
            chk("frm_err", frm_err, exp_err[cyc]);
            chk("busy", busy, m_busy);
            chk("rx_data", rx_data, m_rx);
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input logic [W-1:0] v);
        tx_data = v;
        wrt_tx  = 1'b1;
        ticks(1);
        wrt_tx  = 1'b0;
        ticks(2);
    endtask

    // Mode-3 master: drive on fall, sample on rise; any link change is seen 3 clk later
    task automatic frame(input logic [W-1:0] mo, input int nr, input bit up, input int extra,
                         output logic [W-1:0] rd);
        rd = '0;
        bus.SS_n = 1'b0;
        exp_on[cyc+3] = 1'b1;
        ticks(H);
        for (int j = 1; j <= nr + extra; j++) begin
            bus.SCLK = 1'b0;
            if (j <= W) bus.MOSI = mo[W-j];
            ticks(H);
            bus.SCLK = 1'b1;
            if (j <= W) rd[W-j] = bus.MISO;
            if (j == W) begin
                exp_rdy[cyc+3]  = 1'b1;
                exp_word[cyc+3] = mo;
            end
            ticks(H);
        end
        if (up) begin
            bus.SS_n = 1'b1;
            if (nr < W) exp_err[cyc+3] = 1'b1;
            exp_off[cyc+3] = 1'b1;
            ticks(H);
        end
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        ticks(3);
        chk("reset rx_data", rx_data, 16'h0000);
        chk("reset miso", bus.MISO, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset rdy", rdy, 1'b0);
        chk("reset frm_err", frm_err, 1'b0);
        rst_n = 1'b1;
        ticks(3);

        load(16'hA5C3);
        frame(16'h1234, W, 1'b1, 0, mi);
        chk("t1 master read", mi, 16'hA5C3);
        chk("t1 rx_data", rx_data, 16'h1234);

        load(16'h0F0F);
        frame(16'hFFFF, W, 1'b1, 0, mi);
        chk("t2a master read", mi, 16'h0F0F);
        chk("t2a rx_data", rx_data, 16'hFFFF);
        load(16'hF0F0);
        frame(16'h0000, W, 1'b1, 0, mi);
        chk("t2b master read", mi, 16'hF0F0);
        chk("t2b rx_data", rx_data, 16'h0000);

        load(16'h1111);
        frame(16'hABCD, 7, 1'b1, 0, mi);
        chk("t3 rx_data kept", rx_data, 16'h0000);
        chk("t3 idle", busy, 1'b0);

        load(16'h5A5A);
        fork
            frame(16'hC33C, W, 1'b1, 0, mi);
            begin
                ticks(60);
                load(16'hDEAD);
            end
        join
        chk("t4 master read", mi, 16'h5A5A);
        chk("t4 rx_data", rx_data, 16'hC33C);

        load(16'h0001);
        frame(16'h7E81, W, 1'b1, 3, mi);
        chk("t5 master read", mi, 16'h0001);
        chk("t5 rx_data", rx_data, 16'h7E81);

        load(16'hFFFF);
        frame(16'h1357, 9, 1'b0, 0, mi);
        rst_n = 1'b0;
        exp_rst[cyc] = 1'b1;
        ticks(1);
        chk("t6 rx_data cleared", rx_data, 16'h0000);
        chk("t6 busy cleared", busy, 1'b0);
        chk("t6 miso cleared", bus.MISO, 1'b0);
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        load(16'h3C5A);
        frame(16'h8001, W, 1'b1, 0, mi);
        chk("t6 master read", mi, 16'h3C5A);
        chk("t6 rx_data", rx_data, 16'h8001);

        ticks(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
